// File: rtl/req_arbiter_8.sv
// req_arbiter_8: shares one resource among 8 requesters.
// The highest-index request wins. Once granted, an owner keeps the grant
// until it drops its request or until it has held it for MAX_HOLD cycles.
// A revoked owner is masked for the next arbitration only.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate on every edge
// GRANT   | owner holds the resource; hold_cnt counts held cycles
// RELEASE | single dead cycle between owners; arbitrate at its end
module req_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  output logic [7:0] o_grant,
  output logic [3:0] o_grant_id,
  output logic       o_busy,
  output logic       o_timeout
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_owner;
  logic [2:0]    w_owner_nxt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic [7:0]    r_mask;
  logic [7:0]    w_mask_nxt;
  logic [7:0]    r_grant;
  logic [7:0]    w_grant_nxt;
  logic [3:0]    r_grant_id;
  logic [3:0]    w_grant_id_nxt;
  logic          r_timeout;
  logic          w_timeout_nxt;

  logic [7:0]    w_cand_masked;
  logic [7:0]    w_cand;
  logic          w_found;
  logic [2:0]    w_win;

  // Candidate selection: fall back to the raw requests when the mask would
  // leave nothing to grant, then pick the highest set bit.
  always_comb begin
    w_cand_masked = i_req & ~r_mask;
    w_cand        = (w_cand_masked != 8'd0) ? w_cand_masked : i_req;
    w_found       = 1'b0;
    w_win         = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_cand[i]) begin
        w_found = 1'b1;
        w_win   = 3'(i);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_hold_nxt     = r_hold_cnt;
    w_mask_nxt     = r_mask;
    w_timeout_nxt  = 1'b0;
    w_grant_nxt    = 8'd0;
    w_grant_id_nxt = 4'd0;

    case (r_state)
      IDLE, RELEASE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_win;
          w_hold_nxt  = '0;
          w_mask_nxt  = 8'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (!i_req[r_owner]) begin
          w_state_nxt = RELEASE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt   = RELEASE;
          w_timeout_nxt = 1'b1;
          w_mask_nxt    = 8'd1 << r_owner;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_state_nxt == GRANT) begin
      w_grant_nxt    = 8'd1 << w_owner_nxt;
      w_grant_id_nxt = {1'b0, w_owner_nxt} + 4'd1;
    end
  end

  // State and registered outputs; synchronous active-low reset wins over all.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 3'd0;
      r_hold_cnt <= '0;
      r_mask     <= 8'd0;
      r_grant    <= 8'd0;
      r_grant_id <= 4'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_mask     <= w_mask_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_grant_id = r_grant_id;
  assign o_busy     = (r_state == GRANT);
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed bench for req_arbiter_8 with MAX_HOLD=4.
module tb_req_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [3:0] grant_id;
  logic       busy;
  logic       timeout;

  int n_vec  = 0;
  int n_fail = 0;

  req_arbiter_8 #(.MAX_HOLD(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .o_grant    (grant),
    .o_grant_id (grant_id),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [3:0] id,
                         input logic b, input logic t);
    chk({tag, ".grant"},    32'(grant),    32'(g));
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(id));
    chk({tag, ".busy"},     32'(busy),     32'(b));
    chk({tag, ".timeout"},  32'(timeout),  32'(t));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;

    // 1: reset held for 3 edges with all requests high
    repeat (3) tick();
    chk_all("reset", 8'h00, 4'd0, 1'b0, 1'b0);

    // 2: highest of two requests wins, one edge later
    rst_n = 1'b1;
    req   = 8'b0010_0100;
    tick();
    chk_all("first_grant", 8'h20, 4'b0110, 1'b1, 1'b0);

    // 3: no preemption by req[7]; release gap; then req[7] wins
    req = 8'hA4;
    tick();
    chk_all("no_preempt", 8'h20, 4'b0110, 1'b1, 1'b0);
    req = 8'h84;
    tick();
    chk_all("drop_gap", 8'h00, 4'd0, 1'b0, 1'b0);
    tick();
    chk_all("next_owner", 8'h80, 4'b1000, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    tick();
    chk_all("idle", 8'h00, 4'd0, 1'b0, 1'b0);

    // 4: hold limit with two requesters; masking hands over to req[0]
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("hold81_%0d", i), 8'h80, 4'b1000, 1'b1, 1'b0);
    end
    tick();
    chk_all("timeout81", 8'h00, 4'd0, 1'b0, 1'b1);
    tick();
    chk_all("masked_win", 8'h01, 4'b0001, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_all("rel0", 8'h00, 4'd0, 1'b0, 1'b0);
    tick();

    // 5: single requester; mask falls back to raw requests
    req = 8'h08;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("hold08_%0d", i), 8'h08, 4'b0100, 1'b1, 1'b0);
    end
    tick();
    chk_all("timeout08", 8'h00, 4'd0, 1'b0, 1'b1);
    tick();
    chk_all("regrant08", 8'h08, 4'b0100, 1'b1, 1'b0);

    // 6: one-edge reset mid-grant, then re-grant one edge after release
    tick();
    rst_n = 1'b0;
    tick();
    chk_all("mid_reset", 8'h00, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("post_reset", 8'h08, 4'b0100, 1'b1, 1'b0);

    // short request in the first grant cycle still yields one grant cycle
    req = 8'h00;
    tick();
    tick();
    req = 8'h02;
    tick();
    req = 8'h00;
    chk_all("short_req", 8'h02, 4'b0010, 1'b1, 1'b0);
    tick();
    chk_all("short_rel", 8'h00, 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
